// File: rtl/fwd_hazard_unit.sv
// EX-operand forwarding select and load-use stall unit; selects registered (1 cycle), stall combinational.
// No backpressure of its own: stall holds the front end; FWD_WB_EN adds the late (11) forwarding source.
module fwd_hazard_unit #(
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] id_rs,
   input  logic [ADDR_W-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic [ADDR_W-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              flush,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              stall,
   output logic [CNT_W-1:0]  stall_count
);

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] rd;
      logic              reg_write;
   } tag_t;

   localparam tag_t BUBBLE = '{valid: 1'b0, rd: '0, reg_write: 1'b0};

   // The load flag only matters while the producer sits in EX.
   tag_t             ex_q, ex_d, mem_q;
   logic             ex_load_q, ex_load_d;
`ifdef FWD_WB_EN
   tag_t             wb_q, late_q;
`endif
   logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bubble;

   function automatic logic hit(input tag_t t, input logic [ADDR_W-1:0] a);
      return t.valid && t.reg_write && (t.rd != '0) && (t.rd == a);
   endfunction

`ifdef FWD_WB_EN
   function automatic logic [1:0] sel(input logic use_src, input logic [ADDR_W-1:0] src,
                                      input tag_t t_ex, input tag_t t_mem, input tag_t t_wb);
      if (!use_src)             return 2'b00;
      else if (hit(t_ex, src))  return 2'b10;
      else if (hit(t_mem, src)) return 2'b01;
      else if (hit(t_wb, src))  return 2'b11;
      else                      return 2'b00;
   endfunction
`else
   function automatic logic [1:0] sel(input logic use_src, input logic [ADDR_W-1:0] src,
                                      input tag_t t_ex, input tag_t t_mem);
      if (!use_src)             return 2'b00;
      else if (hit(t_ex, src))  return 2'b10;
      else if (hit(t_mem, src)) return 2'b01;
      else                      return 2'b00;
   endfunction
`endif

   always_comb begin
      stall     = 1'b0;
      bubble    = 1'b0;
      ex_d      = BUBBLE;
      ex_load_d = 1'b0;
      fwd_a_d   = 2'b00;
      fwd_b_d   = 2'b00;
      cnt_d     = cnt_q;

      // Flush kills the consumer, so it suppresses the stall as well.
      stall = id_valid && !flush && ex_q.valid && ex_load_q && ex_q.reg_write &&
              (ex_q.rd != '0) &&
              ((id_use_rs && (id_rs == ex_q.rd)) || (id_use_rt && (id_rt == ex_q.rd)));
      bubble = stall || flush || !id_valid;

      if (!bubble) begin
         ex_d      = '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write};
         ex_load_d = id_mem_read;
`ifdef FWD_WB_EN
         fwd_a_d   = sel(id_use_rs, id_rs, ex_q, mem_q, wb_q);
         fwd_b_d   = sel(id_use_rt, id_rt, ex_q, mem_q, wb_q);
`else
         fwd_a_d   = sel(id_use_rs, id_rs, ex_q, mem_q);
         fwd_b_d   = sel(id_use_rt, id_rt, ex_q, mem_q);
`endif
      end

      if (stall && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q      <= BUBBLE;
         ex_load_q <= 1'b0;
         mem_q     <= BUBBLE;
`ifdef FWD_WB_EN
         wb_q      <= BUBBLE;
         late_q    <= BUBBLE;
`endif
         fwd_a_q   <= 2'b00;
         fwd_b_q   <= 2'b00;
         cnt_q     <= '0;
      end else begin
`ifdef FWD_WB_EN
         late_q    <= wb_q;
         wb_q      <= mem_q;
`endif
         mem_q     <= ex_q;
         ex_q      <= ex_d;
         ex_load_q <= ex_load_d;
         fwd_a_q   <= fwd_a_d;
         fwd_b_q   <= fwd_b_d;
         cnt_q     <= cnt_d;
      end
   end

   assign fwd_a       = fwd_a_q;
   assign fwd_b       = fwd_b_q;
   assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: instruction-stream vector table plus hand sequences.
module tb_fwd_hazard_unit;

   localparam logic [1:0] LATE =
`ifdef FWD_WB_EN
      2'b11;
`else
      2'b00;
`endif

   typedef struct {
      logic       rst, vld;
      logic [4:0] rs;
      logic       urs;
      logic [4:0] rt;
      logic       urt;
      logic [4:0] rd;
      logic       rw, mr, fl;
      logic       st;
      logic [1:0] fa, fb;
      int         cnt;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0;
   logic        id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;
   logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
   logic [1:0]  fwd_a, fwd_b, fwd_a2, fwd_b2;
   logic        stall, stall2;
   logic [15:0] stall_count;
   logic [1:0]  stall_count2;

   int tests = 0;
   int fails = 0;
   vec_t exp_q[$];
   vec_t vecs[26];

   always #5 clk = ~clk;

   fwd_hazard_unit #(.ADDR_W(5), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .stall_count(stall_count));

   // Narrow counter copy so saturation is reachable in a short run.
   fwd_hazard_unit #(.ADDR_W(5), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
      .fwd_a(fwd_a2), .fwd_b(fwd_b2), .stall(stall2), .stall_count(stall_count2));

   function automatic vec_t mk(input logic rst, input logic vld, input logic [4:0] rs,
                               input logic urs, input logic [4:0] rt, input logic urt,
                               input logic [4:0] rd, input logic rw, input logic mr,
                               input logic fl, input logic st, input logic [1:0] fa,
                               input logic [1:0] fb, input int cnt);
      vec_t v;
      v.rst = rst; v.vld = vld; v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt;
      v.rd = rd; v.rw = rw; v.mr = mr; v.fl = fl; v.st = st; v.fa = fa; v.fb = fb;
      v.cnt = cnt;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input string tag, input vec_t v);
      vec_t e;
      int   sat;
      @(negedge clk);
      reset = v.rst; id_valid = v.vld; id_rs = v.rs; id_use_rs = v.urs;
      id_rt = v.rt; id_use_rt = v.urt; id_rd = v.rd; id_reg_write = v.rw;
      id_mem_read = v.mr; flush = v.fl;
      #1;
      check({tag, ".stall"}, int'(stall), int'(v.st));
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      sat = (e.cnt > 3) ? 3 : e.cnt;
      check({tag, ".fwd_a"}, int'(fwd_a), int'(e.fa));
      check({tag, ".fwd_b"}, int'(fwd_b), int'(e.fb));
      check({tag, ".stall_count"}, int'(stall_count), e.cnt);
      check({tag, ".sat_count"}, int'(stall_count2), sat);
      check({tag, ".sat_sel"}, int'({fwd_a2, fwd_b2}), int'({e.fa, e.fb}));
   endtask

   initial begin
      int c;
      //         rst vld rs  urs rt urt rd rw mr fl  st fa     fb     cnt
      vecs[0]  = mk(0, 1, 1,  1, 2, 1, 5,  1, 0, 0, 0, 2'b00, 2'b00, 0);
      vecs[1]  = mk(0, 1, 5,  1, 3, 1, 6,  1, 0, 0, 0, 2'b10, 2'b00, 0);
      vecs[2]  = mk(0, 1, 0,  0, 0, 0, 7,  1, 0, 0, 0, 2'b00, 2'b00, 0);
      vecs[3]  = mk(0, 1, 1,  1, 2, 1, 7,  1, 0, 0, 0, 2'b00, 2'b00, 0);
      vecs[4]  = mk(0, 1, 7,  1, 7, 1, 8,  1, 0, 0, 0, 2'b10, 2'b10, 0);
      vecs[5]  = mk(0, 1, 1,  1, 0, 0, 4,  1, 1, 0, 0, 2'b00, 2'b00, 0);
      vecs[6]  = mk(0, 1, 4,  1, 2, 1, 10, 1, 0, 0, 1, 2'b00, 2'b00, 1);
      vecs[7]  = mk(0, 1, 4,  1, 2, 1, 10, 1, 0, 0, 0, 2'b01, 2'b00, 1);
      vecs[8]  = mk(0, 1, 0,  0, 0, 0, 0,  1, 0, 0, 0, 2'b00, 2'b00, 1);
      vecs[9]  = mk(0, 1, 0,  1, 4, 0, 11, 1, 0, 0, 0, 2'b00, 2'b00, 1);
      vecs[10] = mk(0, 1, 0,  0, 0, 0, 4,  1, 1, 0, 0, 2'b00, 2'b00, 1);
      vecs[11] = mk(0, 1, 1,  1, 4, 0, 12, 1, 0, 0, 0, 2'b00, 2'b00, 1);
      vecs[12] = mk(0, 1, 0,  0, 0, 0, 4,  1, 1, 0, 0, 2'b00, 2'b00, 1);
      vecs[13] = mk(0, 1, 4,  1, 0, 0, 13, 1, 0, 1, 0, 2'b00, 2'b00, 1);
      vecs[14] = mk(0, 1, 4,  1, 0, 0, 14, 1, 0, 0, 0, 2'b01, 2'b00, 1);
      vecs[15] = mk(0, 1, 0,  0, 0, 0, 9,  1, 0, 0, 0, 2'b00, 2'b00, 1);
      vecs[16] = mk(0, 1, 0,  0, 0, 0, 20, 1, 0, 0, 0, 2'b00, 2'b00, 1);
      vecs[17] = mk(0, 1, 0,  0, 0, 0, 21, 1, 0, 0, 0, 2'b00, 2'b00, 1);
      vecs[18] = mk(0, 1, 9,  1, 2, 1, 22, 1, 0, 0, 0, LATE,  2'b00, 1);
      vecs[19] = mk(0, 1, 22, 1, 21, 1, 23, 1, 0, 0, 0, 2'b10, 2'b01, 1);
      vecs[20] = mk(0, 1, 0,  0, 0, 0, 5,  1, 1, 0, 0, 2'b00, 2'b00, 1);
      vecs[21] = mk(0, 1, 1,  1, 5, 1, 24, 1, 0, 0, 1, 2'b00, 2'b00, 2);
      vecs[22] = mk(0, 1, 1,  1, 5, 1, 24, 1, 0, 0, 0, 2'b00, 2'b01, 2);
      vecs[23] = mk(0, 1, 0,  0, 0, 0, 0,  1, 1, 0, 0, 2'b00, 2'b00, 2);
      vecs[24] = mk(0, 1, 0,  1, 0, 1, 25, 1, 0, 0, 0, 2'b00, 2'b00, 2);
      vecs[25] = mk(0, 0, 25, 1, 0, 0, 26, 1, 0, 0, 0, 2'b00, 2'b00, 2);

      repeat (2) @(posedge clk);
      #1;
      check("reset.fwd_a", int'(fwd_a), 0);
      check("reset.fwd_b", int'(fwd_b), 0);
      check("reset.stall", int'(stall), 0);
      check("reset.stall_count", int'(stall_count), 0);

      for (int i = 0; i < 26; i++) begin
         step($sformatf("vec%0d", i), vecs[i]);
      end

      // Repeated load-use pairs drive the 2-bit counter into saturation.
      c = 2;
      for (int k = 0; k < 3; k++) begin
         step($sformatf("sat%0d.lw", k), mk(0, 1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 2'b00, 2'b00, c));
         c++;
         step($sformatf("sat%0d.use", k), mk(0, 1, 6, 1, 0, 0, 27, 1, 0, 0, 1, 2'b00, 2'b00, c));
         step($sformatf("sat%0d.fwd", k), mk(0, 1, 6, 1, 0, 0, 27, 1, 0, 0, 0, 2'b01, 2'b00, c));
      end

      // Mid-stream reset: the r9 producer must be forgotten.
      step("rst.wr9",  mk(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 2'b00, 2'b00, c));
      step("rst.edge", mk(1, 1, 9, 1, 0, 0, 30, 1, 0, 0, 0, 2'b00, 2'b00, 0));
      step("rst.after", mk(0, 1, 9, 1, 9, 1, 31, 1, 0, 0, 0, 2'b00, 2'b00, 0));

      check("scoreboard.empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised successor to the combinational forwarding unit. It tracks destination tags of in-flight instructions in an internal EX/MEM/WB shadow pipeline and produces registered, correctly prioritised forwarding selects for both EX-stage operands. It also detects load-use hazards, stalls the front end for one cycle, injects a bubble, and keeps a saturating stall-cycle counter. It sits beside the ID/EX pipeline register and is fed from decode.

## Interface
Parameters:
- ADDR_W, 5, register-address width
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  decode slot holds a real instruction
- id_rs  in  ADDR_W  source A of decoding instruction
- id_rt  in  ADDR_W  source B of decoding instruction
- id_use_rs  in  1  instruction actually reads rs
- id_use_rt  in  1  instruction actually reads rt
- id_rd  in  ADDR_W  destination register
- id_reg_write  in  1  instruction writes the register file
- id_mem_read  in  1  instruction is a load
- flush  in  1  kill the decoding instruction (branch taken)
- fwd_a  out  2  EX operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB, 11 WB-late
- fwd_b  out  2  EX operand B select, same encoding
- stall  out  1  combinational; hold PC and IF/ID, bubble ID/EX
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- Shadow tags per stage (ex, mem, wb, plus late with FWD_WB_EN): valid, rd, reg_write, mem_read.
- A stage is a forward source only when valid && reg_write && rd != 0.
- Per edge (reset low):
  - late <= wb
  - wb <= mem
  - mem <= ex
  - ex <= bubble if stall, flush, or !id_valid; otherwise id_* fields
- Load-use: stall = id_valid && !flush && ex.valid && ex.mem_read && ex.reg_write && ex.rd != 0 && ((id_use_rs && id_rs == ex.rd) || (id_use_rt && id_rt == ex.rd)).
- Forwarding selects are registered. They are computed from id_rs/id_rt against the tags about to occupy MEM (current ex), WB (current mem) and late (current wb).
- Priority: youngest wins, so 10 over 01 over 11. A source with its id_use_* low gets 00.
- On bubble (stall, flush, !id_valid), fwd_a/fwd_b load 00.
- rs and rt are evaluated independently; both may forward, from different stages.
- stall_count increments on each cycle stall is high and holds at 2^CNT_W-1.
- flush and stall together: flush wins for the bubble. Stall is suppressed, so the counter does not increment.

## Timing
- Reset: all tags invalid; fwd_a = fwd_b = 00; stall_count = 0. stall is therefore 0.
- A reset mid-operation discards all in-flight tags on that edge.
- fwd_a/fwd_b are valid for the full cycle the instruction occupies EX: one cycle after it is accepted from ID.
- stall is asserted in the same cycle the consumer is in ID with the load in EX.
- Exactly one stall cycle per load-use pair. The next cycle, the load tag is in MEM, so the consumer gets 01 in EX.
- An instruction with id_rd = 0 and reg_write = 1 never forwards and never stalls.

## Configuration
- FWD_WB_EN defined:
  - The late tag stage exists.
  - Select 11 forwards the value written back one cycle earlier, for register files without write-through.
- FWD_WB_EN undefined:
  - No late stage exists and 11 is never produced.
  - Matches from the current wb tag give 00.

## Test plan
- Back-to-back ALU dependence:
  - Stimulus: add r5 (rd=5, reg_write), then sub using rs=5, rt=3.
  - Response: sub in EX sees fwd_a=10, fwd_b=00; stall=0.
- Double hazard priority:
  - Stimulus: write r7, write r7, then read rs=7, rt=7.
  - Response: fwd_a=10, fwd_b=10, not 01.
- Load-use:
  - Stimulus: lw r4 (mem_read), then add with rs=4.
  - Response: stall=1 for exactly one cycle; a bubble enters ex; add then reaches EX with fwd_a=01; stall_count=1.
- r0 and unused sources:
  - Stimulus: write r0, then read rs=0.
  - Response: fwd_a=00.
  - Stimulus: lw r4, then an instruction with rt=4 and id_use_rt=0.
  - Response: no stall.
- Flush and reset:
  - Stimulus: a load-use pair with flush=1 in the stall cycle.
  - Response: stall=0, stall_count unchanged, ex holds a bubble.
  - Stimulus: reset asserted mid-stream.
  - Response: next cycle fwd_a=fwd_b=00, stall_count=0.
- FWD_WB_EN:
  - Stimulus: write r9, two unrelated instructions, then read rs=9.
  - Response: fwd_a=11 with the macro; 00 without it.
